ghost_sprite_renderer: RTL

//   Consumer side of the ghost position/direction outputs: turns a ghost's x/y/direction into
//   per-pixel colour for the VGA scan. Sits between a ghost mover and the VGA pixel mux.

---
 rtl/ghost_pkg.sv | 60 ++++++
 rtl/ghost_sprite_rom.sv | 31 +++
 rtl/ghost_sprite_renderer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/ghost_pkg.sv
// Shared definitions for the ghost sprite renderer: direction and pixel codes,
// screen geometry and the procedural description of the ghost image.
package ghost_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    PX_CLEAR = 2'd0,
    PX_BODY  = 2'd1,
    PX_EYE   = 2'd2,
    PX_PUPIL = 2'd3
  } px_code_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int RGB_W    = 12;

  // Pixel code of the 16x16 ghost at (x, y) for animation phase ph and
  // facing dir. Dome on rows 0-3, solid body on rows 4-13, a skirt on rows
  // 14-15 whose bumps shift by two pixels between phases, and two 4x4 eye
  // whites that lean towards the facing direction with a 2x2 pupil inside.
  function automatic logic [1:0] sprite_code(input int ph, input int dir,
                                             input int y, input int x);
    int shx, shy, pox, poy, ex, ey;
    logic [1:0] code;
    code = PX_CLEAR;
    if (y < 4) begin
      if (x >= 4 - y && x <= 11 + y) code = PX_BODY;
    end else if (y < 14) begin
      code = PX_BODY;
    end else if (y == 14) begin
      if (((x / 2) % 2) == ph) code = PX_BODY;
    end else begin
      if ((x % 4) == 2 * ph) code = PX_BODY;
    end
    case (dir)
      0:       begin shx = 0;  shy = -1; pox = 1; poy = 0; end
      1:       begin shx = 0;  shy = 1;  pox = 1; poy = 2; end
      2:       begin shx = -1; shy = 0;  pox = 0; poy = 1; end
      default: begin shx = 1;  shy = 0;  pox = 2; poy = 1; end
    endcase
    for (int e = 0; e < 2; e++) begin
      ex = ((e == 0) ? 2 : 9) + shx;
      ey = 4 + shy;
      if (x >= ex && x < ex + 4 && y >= ey && y < ey + 4) begin
        if (x >= ex + pox && x < ex + pox + 2 && y >= ey + poy && y < ey + poy + 2)
          code = PX_PUPIL;
        else
          code = PX_EYE;
      end
    end
    return code;
  endfunction

endpackage

// File: rtl/ghost_sprite_rom.sv
// Synchronous-read sprite ROM: {phase, dir, y, x} -> 2-bit pixel code.
// Contents are built from ghost_pkg::sprite_code so the image lives in source.
module ghost_sprite_rom
  import ghost_pkg::*;
#(
  parameter int SPR_W = 16,
  parameter int SPR_H = 16,
  parameter int AW    = 11
) (
  input  logic          clkdiv,
  input  logic [AW-1:0] addr,
  output logic [1:0]    code
);

  localparam int DEPTH = 2 * 4 * SPR_W * SPR_H;

  logic [1:0] rom [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
    assign rom[gi] = sprite_code(gi / (4 * SPR_W * SPR_H),
                                 (gi / (SPR_W * SPR_H)) % 4,
                                 (gi / SPR_W) % SPR_H,
                                 gi % SPR_W);
  end

  // Registered read, block-RAM style.
  always_ff @(posedge clkdiv) begin
    code <= rom[addr];
  end

endmodule

// File: rtl/ghost_sprite_renderer.sv
// Ghost sprite renderer: freezes ghost position once per frame, animates a
// two-phase body wobble and produces per-pixel colour with a fixed 3-cycle
// latency from col/row.
module ghost_sprite_renderer
  import ghost_pkg::*;
#(
  parameter int          SPR_W        = 16,
  parameter int          SPR_H        = 16,
  parameter int          ANIM_FRAMES  = 8,
  parameter logic [11:0] BODY_COLOR   = 12'hF00,
  parameter logic [11:0] FRIGHT_COLOR = 12'h00F,
  parameter logic [11:0] EYE_COLOR    = 12'hFFF,
  parameter logic [11:0] PUPIL_COLOR  = 12'h22F,
  parameter logic [9:0]  HOME_X       = 10'd595,
  parameter logic [8:0]  HOME_Y       = 9'd435
) (
  input  logic        clkdiv,
  input  logic        rst,
  input  logic        frame_start,
  input  logic [9:0]  col,
  input  logic [8:0]  row,
  input  logic [9:0]  ghost_x,
  input  logic [8:0]  ghost_y,
  input  logic [1:0]  ghost_dir,
  input  logic        frightened,
  output logic        pix_on,
  output logic [11:0] pix_rgb,
  output logic        anim_phase
);

  localparam int XB = $clog2(SPR_W);
  localparam int YB = $clog2(SPR_H);
  localparam int AW = 3 + XB + YB;
  localparam int CW = ($clog2(ANIM_FRAMES) > 3) ? $clog2(ANIM_FRAMES) : 3;

  logic [9:0]    sx_reg;
  logic [8:0]    sy_reg;
  logic [1:0]    sdir_reg;
  logic          sfr_reg;
  logic [CW-1:0] anim_cnt_reg;
  logic          anim_reg;

  // Shadow registers and animation counter advance only on frame_start.
  always_ff @(posedge clkdiv) begin
    if (!rst) begin
      sx_reg       <= HOME_X;
      sy_reg       <= HOME_Y;
      sdir_reg     <= DIR_LEFT;
      sfr_reg      <= 1'b0;
      anim_cnt_reg <= '0;
      anim_reg     <= 1'b0;
    end else if (frame_start) begin
      sx_reg   <= ghost_x;
      sy_reg   <= ghost_y;
      sdir_reg <= ghost_dir;
      sfr_reg  <= frightened;
      if (anim_cnt_reg == CW'(ANIM_FRAMES - 1)) begin
        anim_cnt_reg <= '0;
        anim_reg     <= ~anim_reg;
      end else begin
        anim_cnt_reg <= anim_cnt_reg + CW'(1);
      end
    end
  end

  assign anim_phase = anim_reg;

  // S1 offsets as 11-bit two's complement; a set sign bit means off-box,
  // so right/bottom overhang clips instead of wrapping.
  logic [10:0] dx, dy;
  logic        in_box;

  // Stage 1: offset from sprite origin and box test.
  always_comb begin
    dx     = {1'b0, col} - {1'b0, sx_reg};
    dy     = {2'b0, row} - {2'b0, sy_reg};
    in_box = !dx[10] && (dx[9:0] < 10'(SPR_W)) &&
             !dy[10] && (dy[9:0] < 10'(SPR_H));
  end

  logic [XB-1:0] s1_dx_reg;
  logic [YB-1:0] s1_dy_reg;
  logic [1:0]    s1_dir_reg;
  logic          s1_fr_reg, s1_anim_reg, s1_in_box_reg, s1_valid_reg;

  // Stage 1 register: offsets plus the frozen per-frame attributes.
  always_ff @(posedge clkdiv) begin
    if (!rst) begin
      s1_valid_reg  <= 1'b0;
      s1_in_box_reg <= 1'b0;
    end else begin
      s1_valid_reg  <= 1'b1;
      s1_in_box_reg <= in_box;
    end
    s1_dx_reg   <= dx[XB-1:0];
    s1_dy_reg   <= dy[YB-1:0];
    s1_dir_reg  <= sdir_reg;
    s1_fr_reg   <= sfr_reg;
    s1_anim_reg <= anim_reg;
  end

  logic [AW-1:0] rom_addr;
  logic [1:0]    rom_code;

  assign rom_addr = {s1_anim_reg, s1_dir_reg, s1_dy_reg, s1_dx_reg};

  ghost_sprite_rom #(
    .SPR_W (SPR_W),
    .SPR_H (SPR_H),
    .AW    (AW)
  ) u_rom (
    .clkdiv (clkdiv),
    .addr   (rom_addr),
    .code   (rom_code)
  );

  logic s2_valid_reg, s2_in_box_reg, s2_fr_reg;

  // Stage 2 register: side-band delayed to line up with the ROM read.
  always_ff @(posedge clkdiv) begin
    if (!rst) begin
      s2_valid_reg  <= 1'b0;
      s2_in_box_reg <= 1'b0;
    end else begin
      s2_valid_reg  <= s1_valid_reg;
      s2_in_box_reg <= s1_in_box_reg;
    end
    s2_fr_reg <= s1_fr_reg;
  end

  logic        pix_on_next;
  logic [11:0] pix_rgb_next;

  // Stage 3: map pixel code to palette; anything off-box is transparent black.
  always_comb begin
    pix_on_next  = 1'b0;
    pix_rgb_next = '0;
    if (s2_valid_reg && s2_in_box_reg) begin
      case (px_code_t'(rom_code))
        PX_BODY: begin
          pix_on_next  = 1'b1;
          pix_rgb_next = s2_fr_reg ? FRIGHT_COLOR : BODY_COLOR;
        end
        PX_EYE: begin
          pix_on_next  = 1'b1;
          pix_rgb_next = EYE_COLOR;
        end
        PX_PUPIL: begin
          pix_on_next  = 1'b1;
          pix_rgb_next = s2_fr_reg ? EYE_COLOR : PUPIL_COLOR;
        end
        default: begin
          pix_on_next  = 1'b0;
          pix_rgb_next = '0;
        end
      endcase
    end
  end

  // Output register; reset clears any pixel in flight.
  always_ff @(posedge clkdiv) begin
    if (!rst) begin
      pix_on  <= 1'b0;
      pix_rgb <= '0;
    end else begin
      pix_on  <= pix_on_next;
      pix_rgb <= pix_rgb_next;
    end
  end

endmodule
